// File: rtl/frida_conv_sched.sv
// FRIDA SAR ADC conversion scheduler: sequences INIT/SAMP/CMP/LOGIC strobes
// across a 16-channel ADC array with programmable phase lengths.
module frida_conv_sched #(
  parameter int NBITS = 8,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          cont,
  input  logic [15:0]   adc_en,
  input  logic [CW-1:0] t_init,
  input  logic [CW-1:0] t_samp,
  input  logic [CW-1:0] t_cmp,
  input  logic [CW-1:0] t_logic,
  output logic          seq_init,
  output logic          seq_samp,
  output logic          seq_cmp,
  output logic          seq_logic,
  output logic [3:0]    mux_sel,
  output logic          busy,
  output logic          conv_done,
  output logic [3:0]    bit_idx
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SAMP,
    CMP,
    LOGIC,
    NEXT
  } state_t;

  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [3:0] TOP_BIT = 4'(NBITS - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bit_n, mux_n;
  logic          stop_flag, stop_n;
  logic          load;
  logic [CW-1:0] sh_init, sh_samp, sh_cmp, sh_logic;
  logic          sh_cont;
  logic [15:0]   above;
  logic          has_above;
  logic          stop_seen;

  function automatic logic [3:0] low_bit(input logic [15:0] v);
    low_bit = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) low_bit = 4'(i);
    end
  endfunction

  // enabled channels strictly above the current one, and any pending stop
  always_comb begin
    above     = adc_en & ~((16'd2 << mux_sel) - 16'd1);
    has_above = |above;
    stop_seen = stop_flag | stop;
  end

  // next-state, phase counter, bit index and channel pointer
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    mux_n   = mux_sel;
    load    = 1'b0;
    stop_n  = stop_flag | ((state != IDLE) & stop);
    unique case (state)
      IDLE: begin
        if (start && (adc_en != 16'd0)) begin
          state_n = INIT;
          cnt_n   = t_init;
          mux_n   = low_bit(adc_en);
          load    = 1'b1;
        end
      end
      INIT: begin
        if (cnt == '0) begin
          state_n = SAMP;
          cnt_n   = sh_samp;
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      SAMP: begin
        if (cnt == '0) begin
          state_n = CMP;
          cnt_n   = sh_cmp;
          bit_n   = TOP_BIT;
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      CMP: begin
        if (cnt == '0) begin
          state_n = LOGIC;
          cnt_n   = sh_logic;
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      LOGIC: begin
        if (cnt == '0) begin
          if (bit_idx == 4'd0) begin
            state_n = NEXT;
          end else begin
            state_n = CMP;
            cnt_n   = sh_cmp;
            bit_n   = bit_idx - 4'd1;
          end
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      NEXT: begin
        if (stop_seen || (adc_en == 16'd0) ||
            (!sh_cont && !has_above)) begin
          state_n = IDLE;
        end else begin
          state_n = INIT;
          cnt_n   = sh_init;
          mux_n   = has_above ? low_bit(above) : low_bit(adc_en);
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE) stop_n = 1'b0;
  end

  // state, datapath and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 4'd0;
      mux_sel   <= 4'd0;
      stop_flag <= 1'b0;
      sh_init   <= '0;
      sh_samp   <= '0;
      sh_cmp    <= '0;
      sh_logic  <= '0;
      sh_cont   <= 1'b0;
      seq_init  <= 1'b0;
      seq_samp  <= 1'b0;
      seq_cmp   <= 1'b0;
      seq_logic <= 1'b0;
      busy      <= 1'b0;
      conv_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      mux_sel   <= mux_n;
      stop_flag <= stop_n;
      if (load) begin
        sh_init  <= t_init;
        sh_samp  <= t_samp;
        sh_cmp   <= t_cmp;
        sh_logic <= t_logic;
        sh_cont  <= cont;
      end
      seq_init  <= (state_n == INIT);
      seq_samp  <= (state_n == SAMP);
      seq_cmp   <= (state_n == CMP);
      seq_logic <= (state_n == LOGIC);
      busy      <= (state_n != IDLE);
      conv_done <= (state_n == NEXT);
    end
  end

endmodule

// File: tb/tb_frida_conv_sched.sv
// Scoreboard bench for frida_conv_sched: expected conv_done events
// (channel, cycle) are queued at start and popped as the DUT reports them.
module tb_frida_conv_sched;

  localparam int NB = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          cont = 1'b0;
  logic [15:0]   adc_en = '0;
  logic [CW-1:0] t_init = '0;
  logic [CW-1:0] t_samp = '0;
  logic [CW-1:0] t_cmp = '0;
  logic [CW-1:0] t_logic = '0;
  logic          seq_init, seq_samp, seq_cmp, seq_logic;
  logic [3:0]    mux_sel, bit_idx;
  logic          busy, conv_done;

  frida_conv_sched #(.NBITS(NB), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
    .adc_en(adc_en), .t_init(t_init), .t_samp(t_samp), .t_cmp(t_cmp),
    .t_logic(t_logic), .seq_init(seq_init), .seq_samp(seq_samp),
    .seq_cmp(seq_cmp), .seq_logic(seq_logic), .mux_sel(mux_sel),
    .busy(busy), .conv_done(conv_done), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mux;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int conv_len(input int ti, ts, tc, tl);
    return (ti + 1) + (ts + 1) + NB * ((tc + 1) + (tl + 1)) + 1;
  endfunction

  task automatic push(input int mux, input int cyc);
    exp_t e;
    e.mux = mux;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  // act: 1 stop pulse, 2 retune t_*, 3 clear adc_en, 4 rst, 5 start pulse
  task automatic run(input logic [15:0] en, input logic c,
                     input int ti, ts, tc, tl, input int act, input int at,
                     output int n_end, output int ni, output int ns,
                     output int nc, output int nl);
    int eb;
    bit last_logic;
    exp_t e;
    n_end = -1;
    ni = 0; ns = 0; nc = 0; nl = 0;
    eb = NB - 1;
    last_logic = 1'b0;
    @(negedge clk);
    adc_en = en; cont = c;
    t_init = CW'(ti); t_samp = CW'(ts);
    t_cmp = CW'(tc); t_logic = CW'(tl);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      if (n == at) begin
        case (act)
          1: stop = 1'b1;
          2: begin
            t_init = 8'd5; t_samp = 8'd5;
            t_cmp = 8'd5; t_logic = 8'd5;
          end
          3: adc_en = 16'd0;
          4: rst = 1'b1;
          5: start = 1'b1;
          default: ;
        endcase
      end else if (n == at + 1) begin
        stop = 1'b0;
        start = 1'b0;
      end
      ni += int'(seq_init); ns += int'(seq_samp);
      nc += int'(seq_cmp); nl += int'(seq_logic);
      check("onehot", int'(seq_init) + int'(seq_samp) + int'(seq_cmp)
            + int'(seq_logic), (busy && !conv_done) ? 1 : 0);
      if (seq_samp) eb = NB - 1;
      if (seq_cmp && last_logic) eb--;
      if (seq_cmp) check("bit_idx", int'(bit_idx), eb);
      last_logic = seq_logic;
      if (conv_done) begin
        if (sb.size() == 0) begin
          check("extra_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("mux_sel", int'(mux_sel), e.mux);
          check("done_cyc", n, e.cyc);
        end
      end
      if (!busy) begin
        n_end = n;
        break;
      end
      @(negedge clk);
    end
    if (n_end < 0) check("timeout", 0, 1);
    check("sb_empty", sb.size(), 0);
    sb.delete();
    stop = 1'b0;
    start = 1'b0;
  endtask

  int ne, ni, ns, nc, nl, L;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_init", int'(seq_init), 0);
    check("rst_samp", int'(seq_samp), 0);
    check("rst_cmp", int'(seq_cmp), 0);
    check("rst_logic", int'(seq_logic), 0);
    check("rst_mux", int'(mux_sel), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(conv_done), 0);
    check("rst_bit", int'(bit_idx), 0);
    rst = 1'b0;

    L = conv_len(0, 0, 0, 0);
    push(0, L);
    run(16'h0001, 1'b0, 0, 0, 0, 0, 0, 0, ne, ni, ns, nc, nl);
    check("t1_idle", ne, 20);
    check("t1_init", ni, 1);
    check("t1_samp", ns, 1);
    check("t1_cmp", nc, 8);
    check("t1_logic", nl, 8);

    push(0, L); push(5, 2 * L); push(10, 3 * L); push(15, 4 * L);
    run(16'h8421, 1'b0, 0, 0, 0, 0, 5, 30, ne, ni, ns, nc, nl);
    check("t2_idle", ne, 77);
    check("t2_mux_hold", int'(mux_sel), 15);
    check("t2_init", ni, 4);

    L = conv_len(3, 7, 1, 0);
    push(0, L);
    run(16'h0001, 1'b0, 3, 7, 1, 0, 0, 0, ne, ni, ns, nc, nl);
    check("t3_len", L, 37);
    check("t3_idle", ne, 38);
    check("t3_init", ni, 4);
    check("t3_samp", ns, 8);
    check("t3_cmp", nc, 16);
    check("t3_logic", nl, 8);

    L = conv_len(0, 0, 0, 0);
    push(0, L); push(1, 2 * L); push(0, 3 * L); push(1, 4 * L);
    run(16'h0003, 1'b1, 0, 0, 0, 0, 1, 60, ne, ni, ns, nc, nl);
    check("t4_idle", ne, 77);
    check("t4_init", ni, 4);
    check("t4_mux", int'(mux_sel), 1);

    push(0, L); push(1, 2 * L);
    run(16'h0003, 1'b0, 0, 0, 0, 0, 2, 5, ne, ni, ns, nc, nl);
    check("t5_idle", ne, 39);

    push(0, L); push(1, 2 * L);
    run(16'h0007, 1'b1, 0, 0, 0, 0, 3, 25, ne, ni, ns, nc, nl);
    check("t6_idle", ne, 39);
    check("t6_mux", int'(mux_sel), 1);

    run(16'h0010, 1'b0, 0, 3, 0, 0, 4, 2, ne, ni, ns, nc, nl);
    check("t7_abort", ne, 3);
    check("t7_mux", int'(mux_sel), 0);
    check("t7_samp", int'(seq_samp), 0);
    check("t7_done", int'(conv_done), 0);
    check("t7_bit", int'(bit_idx), 0);
    rst = 1'b0;

    @(negedge clk);
    adc_en = 16'd0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t8_busy", int'(busy), 0);
      check("t8_init", int'(seq_init), 0);
    end
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
